// File: rtl/lsu_issue_queue_pkg.sv
// rtl/lsu_issue_queue_pkg.sv - shared LSU issue-queue payload type and tag width
package lsu_issue_queue_pkg;

  localparam int PRF_TAG_W = 6;

  typedef enum logic [1:0] {
    LSU_LOAD  = 2'd0,
    LSU_STORE = 2'd1,
    LSU_AMO   = 2'd2,
    LSU_FENCE = 2'd3
  } lsu_op_e;

  typedef struct packed {
    lsu_op_e              op;
    logic [1:0]           size;
    logic                 sign_ext;
    logic [4:0]           rob_idx;
    logic [PRF_TAG_W-1:0] rd_tag;
    logic [15:0]          imm;
  } LSU_Queue_Meta;

  localparam int LSU_META_W = $bits(LSU_Queue_Meta);

endpackage

// File: rtl/iq_wakeup_match.sv
// rtl/iq_wakeup_match.sv - compares one source tag against both writeback wakeup ports
module iq_wakeup_match
  import lsu_issue_queue_pkg::*;
#(
  parameter int PRF_W = PRF_TAG_W
) (
  input  logic [PRF_W-1:0] tag_i,
  input  logic             wb_wen_0_i,
  input  logic [PRF_W-1:0] wb_tag_0_i,
  input  logic             wb_wen_1_i,
  input  logic [PRF_W-1:0] wb_tag_1_i,
  output logic             hit_o
);

  assign hit_o = (wb_wen_0_i && (wb_tag_0_i == tag_i)) ||
                 (wb_wen_1_i && (wb_tag_1_i == tag_i));

endmodule

// File: rtl/lsu_issue_queue.sv
// rtl/lsu_issue_queue.sv - in-order dual-enqueue single-issue LSU issue queue
// Circular buffer with per-entry operand readiness tracked by writeback wakeup.
module lsu_issue_queue
  import lsu_issue_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PRF_W = PRF_TAG_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        rs_lsu_wen_0,
  input  logic                        rs_lsu_wen_1,
  input  logic [LSU_META_W-1:0]       rs_lsu_dout_0,
  input  logic [LSU_META_W-1:0]       rs_lsu_dout_1,
  input  logic [PRF_W-1:0]            enq_rs_tag_0,
  input  logic [PRF_W-1:0]            enq_rt_tag_0,
  input  logic                        enq_rs_rdy_0,
  input  logic                        enq_rt_rdy_0,
  input  logic [PRF_W-1:0]            enq_rs_tag_1,
  input  logic [PRF_W-1:0]            enq_rt_tag_1,
  input  logic                        enq_rs_rdy_1,
  input  logic                        enq_rt_rdy_1,
  input  logic                        wb_wen_0,
  input  logic                        wb_wen_1,
  input  logic [PRF_W-1:0]            wb_tag_0,
  input  logic [PRF_W-1:0]            wb_tag_1,
  output logic                        rs_lsu_ready,
  output logic                        iss_valid,
  output logic [LSU_META_W-1:0]       iss_data,
  input  logic                        iss_ready,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [LSU_META_W-1:0] payload_q [DEPTH];
  logic [PRF_W-1:0]      rs_tag_q  [DEPTH];
  logic [PRF_W-1:0]      rt_tag_q  [DEPTH];
  logic [DEPTH-1:0]      rs_rdy_q, rs_rdy_d;
  logic [DEPTH-1:0]      rt_rdy_q, rt_rdy_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [DEPTH-1:0]      entry_vld;
  logic [DEPTH-1:0]      rs_hit, rt_hit;
  logic                  enq_rs_hit_0, enq_rt_hit_0, enq_rs_hit_1, enq_rt_hit_1;
  logic                  clr;
  logic                  we_0, we_1, deq;
  logic [1:0]            enq_n;
  logic [PTR_W-1:0]      slot1_ptr;

  assign clr  = rst | flush;

  // Ready looks only at registered occupancy so dispatch never waits on this cycle's issue.
  assign rs_lsu_ready = (count_q <= CNT_W'(DEPTH - 2));
  assign iss_valid    = (count_q != '0) & rs_rdy_q[head_q] & rt_rdy_q[head_q];
  assign iss_data     = payload_q[head_q];
  assign count        = count_q;

  assign we_0      = rs_lsu_wen_0 & rs_lsu_ready & ~clr;
  assign we_1      = rs_lsu_wen_1 & rs_lsu_ready & ~clr;
  assign deq       = iss_valid & iss_ready;
  assign enq_n     = {1'b0, we_0} + {1'b0, we_1};
  assign slot1_ptr = we_0 ? tail_q + PTR_W'(1) : tail_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    logic [PTR_W-1:0] off;
    assign off          = PTR_W'(g) - head_q;
    assign entry_vld[g] = ({1'b0, off} < count_q);

    iq_wakeup_match #(.PRF_W(PRF_W)) u_rs_match (
      .tag_i(rs_tag_q[g]), .wb_wen_0_i(wb_wen_0), .wb_tag_0_i(wb_tag_0),
      .wb_wen_1_i(wb_wen_1), .wb_tag_1_i(wb_tag_1), .hit_o(rs_hit[g])
    );
    iq_wakeup_match #(.PRF_W(PRF_W)) u_rt_match (
      .tag_i(rt_tag_q[g]), .wb_wen_0_i(wb_wen_0), .wb_tag_0_i(wb_tag_0),
      .wb_wen_1_i(wb_wen_1), .wb_tag_1_i(wb_tag_1), .hit_o(rt_hit[g])
    );
  end

  // Bypass: a tag written back in the enqueue cycle would otherwise never wake the entry.
  iq_wakeup_match #(.PRF_W(PRF_W)) u_enq_rs_match_0 (
    .tag_i(enq_rs_tag_0), .wb_wen_0_i(wb_wen_0), .wb_tag_0_i(wb_tag_0),
    .wb_wen_1_i(wb_wen_1), .wb_tag_1_i(wb_tag_1), .hit_o(enq_rs_hit_0)
  );
  iq_wakeup_match #(.PRF_W(PRF_W)) u_enq_rt_match_0 (
    .tag_i(enq_rt_tag_0), .wb_wen_0_i(wb_wen_0), .wb_tag_0_i(wb_tag_0),
    .wb_wen_1_i(wb_wen_1), .wb_tag_1_i(wb_tag_1), .hit_o(enq_rt_hit_0)
  );
  iq_wakeup_match #(.PRF_W(PRF_W)) u_enq_rs_match_1 (
    .tag_i(enq_rs_tag_1), .wb_wen_0_i(wb_wen_0), .wb_tag_0_i(wb_tag_0),
    .wb_wen_1_i(wb_wen_1), .wb_tag_1_i(wb_tag_1), .hit_o(enq_rs_hit_1)
  );
  iq_wakeup_match #(.PRF_W(PRF_W)) u_enq_rt_match_1 (
    .tag_i(enq_rt_tag_1), .wb_wen_0_i(wb_wen_0), .wb_tag_0_i(wb_tag_0),
    .wb_wen_1_i(wb_wen_1), .wb_tag_1_i(wb_tag_1), .hit_o(enq_rt_hit_1)
  );

  always_comb begin
    rs_rdy_d = rs_rdy_q | (rs_hit & entry_vld);
    rt_rdy_d = rt_rdy_q | (rt_hit & entry_vld);
    if (we_0) begin
      rs_rdy_d[tail_q] = enq_rs_rdy_0 | enq_rs_hit_0;
      rt_rdy_d[tail_q] = enq_rt_rdy_0 | enq_rt_hit_0;
    end
    if (we_1) begin
      rs_rdy_d[slot1_ptr] = enq_rs_rdy_1 | enq_rs_hit_1;
      rt_rdy_d[slot1_ptr] = enq_rt_rdy_1 | enq_rt_hit_1;
    end
    tail_d  = tail_q + PTR_W'(enq_n);
    head_d  = head_q + PTR_W'(deq);
    count_d = count_q + CNT_W'(enq_n) - CNT_W'(deq);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      rs_rdy_q <= '0;
      rt_rdy_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      rs_rdy_q <= rs_rdy_d;
      rt_rdy_q <= rt_rdy_d;
    end
  end

  // Payload and tags need no reset: an entry is only observed once its slot is occupied.
  always_ff @(posedge clk) begin
    if (we_0) begin
      payload_q[tail_q] <= rs_lsu_dout_0;
      rs_tag_q[tail_q]  <= enq_rs_tag_0;
      rt_tag_q[tail_q]  <= enq_rt_tag_0;
    end
    if (we_1) begin
      payload_q[slot1_ptr] <= rs_lsu_dout_1;
      rs_tag_q[slot1_ptr]  <= enq_rs_tag_1;
      rt_tag_q[slot1_ptr]  <= enq_rt_tag_1;
    end
  end

  enq_overflow_a: assert property (@(posedge clk) disable iff (rst)
    !((rs_lsu_wen_0 | rs_lsu_wen_1) & ~rs_lsu_ready));

endmodule
